// File: rtl/lens_spi_sequencer.sv
`timescale 1ns/1ps
// lens_spi_sequencer
//   Transaction front-end for the lens SPI byte driver. A register write or
//   read request is latched, the write payload is buffered locally, and then
//   the address byte plus every data command go into the driver queues as one
//   gapless burst, so the driver never sees an empty command queue mid-frame.
//   Once the frame is complete, read bytes are popped from the driver RX queue
//   and handed out on a valid/ready stream.
// Ports
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready/req_write/
//   req_addr/req_len                    transaction request
//   wdata_valid/wdata_ready/wdata       write payload stream
//   rdata_valid/rdata_ready/rdata/
//   rdata_last                          read data stream
//   done, err                           end-of-transaction pulse and status
//   drv_command_read/drv_rw             driver command queue push
//   drv_tx_read/drv_tx_data             driver TX queue push
//   drv_rx_read/drv_rx_data             driver RX queue pop (data one cycle later)
//   drv_state                           driver state, 0 = idle
module lens_spi_sequencer #(
    parameter int MAX_LEN     = 14,
    parameter int DRV_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [3:0] req_len,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    input  logic [7:0] wdata,
    output logic       rdata_valid,
    input  logic       rdata_ready,
    output logic [7:0] rdata,
    output logic       rdata_last,
    output logic       done,
    output logic       err,
    output logic       drv_command_read,
    output logic [1:0] drv_rw,
    output logic       drv_tx_read,
    output logic [7:0] drv_tx_data,
    output logic       drv_rx_read,
    input  logic [7:0] drv_rx_data,
    input  logic [3:0] drv_state
);

    localparam int              TMO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       MAX_LEN_L = 4'(MAX_LEN);
    localparam logic [1:0]       RW_TX    = 2'b01;
    localparam logic [1:0]       RW_RX    = 2'b10;

    // A whole frame (address + data) must fit in the driver queues with one
    // slot to spare, otherwise the driver pointers alias full as empty.
    if (MAX_LEN > DRV_DEPTH - 2 || MAX_LEN > 15) begin : g_param_chk
        $error("lens_spi_sequencer: MAX_LEN must be <= DRV_DEPTH-2 and <= 15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_PUSH,
        S_WAIT_START,
        S_WAIT_END,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             write_q, write_d;
    logic [6:0]       addr_q, addr_d;
    logic [3:0]       len_q, len_d;
    // cnt_q is the buffer write pointer in S_COLLECT, the push index in
    // S_PUSH and the number of RX pops issued in S_DRAIN.
    logic [3:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bad_q, bad_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rlast_q, rlast_d;
    logic             pend_q, pend_d;   // RX pop issued last cycle
    logic             buf_we;
    logic             hs;
    logic [7:0]       buf_q [MAX_LEN];

    assign req_ready   = (state_q == S_IDLE);
    assign wdata_ready = (state_q == S_COLLECT);
    assign done        = (state_q == S_DONE) | bad_q;
    assign err         = done & err_q;
    assign rdata_valid = rvalid_q;
    assign rdata       = rdata_q;
    assign rdata_last  = rlast_q;

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        addr_d           = addr_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        tmo_d            = tmo_q;
        bad_d            = 1'b0;
        err_d            = err_q;
        rvalid_d         = rvalid_q;
        rdata_d          = rdata_q;
        rlast_d          = rlast_q;
        pend_d           = pend_q;
        buf_we           = 1'b0;
        hs               = rvalid_q & rdata_ready;
        drv_command_read = 1'b0;
        drv_rw           = 2'b00;
        drv_tx_read      = 1'b0;
        drv_tx_data      = 8'h00;
        drv_rx_read      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                    if (req_len == 4'd0 || req_len > MAX_LEN_L) begin
                        // Rejected in place: status next cycle, no driver traffic.
                        bad_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        state_d = req_write ? S_COLLECT : S_PUSH;
                    end
                end
            end

            S_COLLECT: begin
                if (wdata_valid) begin
                    buf_we = 1'b1;
                    if (cnt_q == len_q - 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = S_PUSH;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_PUSH: begin
                drv_command_read = 1'b1;
                if (cnt_q == 4'd0) begin
                    // Address byte; bit7 set marks a read.
                    drv_rw      = RW_TX;
                    drv_tx_read = 1'b1;
                    drv_tx_data = {~write_q, addr_q};
                end else if (write_q) begin
                    drv_rw      = RW_TX;
                    drv_tx_read = 1'b1;
                    drv_tx_data = buf_q[cnt_q - 4'd1];
                end else begin
                    drv_rw = RW_RX;
                end
                if (cnt_q == len_q) begin
                    cnt_d   = 4'd0;
                    tmo_d   = '0;
                    state_d = S_WAIT_START;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_WAIT_START: begin
                if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (drv_state != 4'd0) state_d = S_WAIT_END;
                end
            end

            S_WAIT_END: begin
                if (drv_state == 4'd0) begin
                    cnt_d    = 4'd0;
                    pend_d   = 1'b0;
                    rvalid_d = 1'b0;
                    state_d  = write_q ? S_DONE : S_DRAIN;
                end else if (tmo_q == TMO_MAX) begin
                    // Frame abandoned; any RX bytes stay in the driver queue.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_DRAIN: begin
                if (pend_q) begin
                    rdata_d  = drv_rx_data;
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q == len_q);
                    pend_d   = 1'b0;
                end
                if (hs) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) state_d = S_DONE;
                end
                // Next pop may overlap the handshake of the current byte,
                // giving one byte every two cycles with rdata_ready held high.
                if (!pend_q && (!rvalid_q || hs) && cnt_q != len_q) begin
                    drv_rx_read = 1'b1;
                    pend_d      = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            addr_q   <= 7'd0;
            len_q    <= 4'd0;
            cnt_q    <= 4'd0;
            tmo_q    <= '0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 8'd0;
            rlast_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'd0;
        end else if (buf_we) begin
            buf_q[cnt_q] <= wdata;
        end
    end

endmodule
